// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, default width.
// No logic of its own; imported by mdu_calc and mdu_unit.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_e;

   function automatic logic mdu_is_div(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational signed/unsigned multiply and divide producing the full HI/LO pair.
// Zero latency, no handshake; div_zero flags a divide by zero so the caller can skip the update.
module mdu_calc
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div_zero
);

   logic               is_signed;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      res_hi    = '0;
      res_lo    = '0;
      div_zero  = 1'b0;
      q_mag     = '0;
      r_mag     = '0;
      prod      = '0;
      is_signed = (op == MDU_MULT) || (op == MDU_DIV);
      a_neg     = is_signed & a[WIDTH-1];
      b_neg     = is_signed & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;

      case (op)
         MDU_MULT, MDU_MULTU: begin
            // Sign-extending to 2*WIDTH makes a plain product correct for both signednesses.
            prod = {{WIDTH{a_neg}}, a} * {{WIDTH{b_neg}}, b};
            {res_hi, res_lo} = prod;
         end
         MDU_DIV, MDU_DIVU: begin
            if (b == '0) begin
               div_zero = 1'b1;
            end else begin
               // Magnitude divide; most-negative / -1 wraps back to most-negative with zero remainder.
               q_mag  = a_mag / b_mag;
               r_mag  = a_mag % b_mag;
               res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
               res_hi = a_neg ? -r_mag : r_mag;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MDU with architectural HI/LO; mult/div results land after MULT_CYCLES/DIV_CYCLES.
// busy is high while in flight; start during busy is ignored (the stall unit must hold it off).
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH       = MDU_WIDTH,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_e       state_q;
   logic [7:0]       cnt_q;
   logic [7:0]       cnt_d;
   logic             busy_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] shadow_hi_q;
   logic [WIDTH-1:0] shadow_lo_q;
   logic             shadow_zero_q;

   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             div_zero;

   mdu_calc #(.WIDTH(WIDTH)) u_calc (
      .op      (op),
      .a       (a),
      .b       (b),
      .res_hi  (res_hi),
      .res_lo  (res_lo),
      .div_zero(div_zero)
   );

   assign cnt_d = cnt_q - 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         busy_q        <= 1'b0;
         hi_q          <= '0;
         lo_q          <= '0;
         shadow_hi_q   <= '0;
         shadow_lo_q   <= '0;
         shadow_zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  case (op)
                     MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                        // Result is computed now from the EX operands and held until the count expires.
                        shadow_hi_q   <= res_hi;
                        shadow_lo_q   <= res_lo;
                        shadow_zero_q <= div_zero;
                        cnt_q         <= mdu_is_div(op) ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
                        busy_q        <= 1'b1;
                        state_q       <= RUN;
                     end
                     MDU_MTHI: hi_q <= a;
                     MDU_MTLO: lo_q <= a;
                     default: begin
                     end
                  endcase
               end
            end
            RUN: begin
               cnt_q <= cnt_d;
               if (cnt_q == 8'd1) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                  if (!shadow_zero_q) begin
                     hi_q <= shadow_hi_q;
                     lo_q <= shadow_lo_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: latency, results, mthi/mtlo, divide by zero, reset abort.
module tb_mdu_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_assert = 0;
   int n_fail   = 0;

   mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .op   (op),
      .a    (a),
      .b    (b),
      .busy (busy),
      .hi   (hi),
      .lo   (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one start pulse; returns at the negedge after the sampling edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      check("idle_before_start", {31'd0, busy}, 32'd0);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int n,
                         input logic [31:0] eh, input logic [31:0] el);
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      int          cyc;
      old_hi = hi;
      old_lo = lo;
      issue(o, x, y);
      cyc = 0;
      while (busy === 1'b1 && cyc < 300) begin
         cyc++;
         check({tag, "_hold_hi"}, hi, old_hi);
         check({tag, "_hold_lo"}, lo, old_lo);
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
      check({tag, "_hi"}, hi, eh);
      check({tag, "_lo"}, lo, el);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);

      run_op("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("multu_maxx2", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("mult_minxmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0);
      run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("divu_7_2", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
      run_op("divu_big", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'd1, 32'h7FFF_FFFC);
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

      issue(3'd4, 32'h11, 32'h0);
      check("mthi_hi", hi, 32'h11);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      issue(3'd5, 32'h22, 32'h0);
      check("mtlo_lo", lo, 32'h22);
      check("mtlo_hi_kept", hi, 32'h11);

      run_op("divu_by0", 3'd3, 32'd100, 32'd0, 10, 32'h11, 32'h22);
      run_op("div_by0", 3'd2, 32'hFFFF_FFF0, 32'd0, 10, 32'h11, 32'h22);

      issue(3'd6, 32'hDEAD_BEEF, 32'd1);
      check("op6_busy", {31'd0, busy}, 32'd0);
      check("op6_hi", hi, 32'h11);
      check("op6_lo", lo, 32'h22);
      issue(3'd7, 32'hDEAD_BEEF, 32'd1);
      check("op7_busy", {31'd0, busy}, 32'd0);
      check("op7_lo", lo, 32'h22);

      issue(3'd5, 32'h1234, 32'h0);
      check("mtlo1234_lo", lo, 32'h1234);
      check("mtlo1234_busy", {31'd0, busy}, 32'd0);

      // Abort a mult with reset during its third busy cycle.
      issue(3'd0, 32'd3, 32'd5);
      check("abort_busy_c1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("abort_busy_c3", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      repeat (8) @(negedge clk);
      check("abort_late_busy", {31'd0, busy}, 32'd0);
      check("abort_late_hi", hi, 32'h0);
      check("abort_late_lo", lo, 32'h0);

      run_op("mult_after_rst", 3'd0, 32'd3, 32'hFFFF_FFFB, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
